// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between IF and MEM requesters.
// MEM normally wins contested grants; IF is forced through after STARVE_MAX consecutive losses.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam logic [3:0] LatInit   = 4'(MEM_LAT);
  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic              we_q;
  logic [3:0]        lat_cnt_q;
  logic [3:0]        starve_cnt_q;
  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

  logic any_req, mem_wins, grant;

  assign any_req  = if_req_i | mem_req_i;
  assign mem_wins = mem_req_i & ~(if_req_i & (starve_cnt_q == StarveLim));
  assign grant    = (state_q == IDLE) & any_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = WAIT;
      WAIT:    if (lat_cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_ready_o  = (state_q == RESP) && (owner_q == OWN_IF);
    mem_ready_o = (state_q == RESP) && (owner_q == OWN_MEM);
    if_stall_o  = if_req_i & ~if_ready_o;
    mem_stall_o = mem_req_i & ~mem_ready_o;
  end

  // Grant-time latching, the latency countdown and the read-data capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      if (grant) begin
        owner_q     <= mem_wins ? OWN_MEM : OWN_IF;
        we_q        <= mem_wins & mem_we_i;
        ram_en_q    <= 1'b1;
        ram_we_q    <= mem_wins & mem_we_i;
        ram_addr_q  <= mem_wins ? mem_addr_i : if_addr_i;
        ram_wdata_q <= mem_wins ? mem_wdata_i : '0;
        lat_cnt_q   <= LatInit;
        if (mem_wins && if_req_i)
          starve_cnt_q <= (starve_cnt_q == StarveLim) ? starve_cnt_q : starve_cnt_q + 4'd1;
        else
          starve_cnt_q <= 4'd0;
      end else if (state_q == WAIT) begin
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
        end else if (owner_q == OWN_IF) begin
          if_rdata_q <= ram_rdata_i;
        end else if (!we_q) begin
          mem_rdata_q <= ram_rdata_i;
        end
      end
    end
  end

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: table rows of request mixes with expected grant order,
// plus hand-written reset sequences.
module tb_dmem_port_arbiter;
  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ifReq = 1'b0, memReq = 1'b0, memWe = 1'b0;
  logic [31:0] ifAddr = '0, memAddr = '0, memWdata = '0, ramRdata = '0;
  logic        ifReady, ifStall, memReady, memStall, ramEn, ramWe;
  logic [31:0] ifRdata, memRdata, ramAddr, ramWdata;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STARVE)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_ready_o(ifReady), .if_rdata_o(ifRdata),
    .if_stall_o(ifStall),
    .mem_req_i(memReq), .mem_we_i(memWe), .mem_addr_i(memAddr), .mem_wdata_i(memWdata),
    .mem_ready_o(memReady), .mem_rdata_o(memRdata), .mem_stall_o(memStall),
    .ram_en_o(ramEn), .ram_we_o(ramWe), .ram_addr_o(ramAddr), .ram_wdata_o(ramWdata),
    .ram_rdata_i(ramRdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } ramEv_t;
  typedef struct { int cyc; logic isWrite; logic [31:0] data; } rdyEv_t;
  typedef struct {
    int ifN; int memN; logic memWe; logic [31:0] memBase; logic [15:0] memMask; int nGrants;
  } vec_t;

  ramEv_t ramQ[$];
  rdyEv_t ifQ[$], memQ[$];

  int total = 0, bad = 0;
  logic [31:0] expIfRdata = '0, expMemRdata = '0;
  int ifN = 0, memN = 0, ifIdx = 0, memIdx = 0;
  logic [31:0] memBaseCur = '0;
  logic monOn = 1'b0;

  function automatic logic [31:0] romVal(input logic [31:0] a);
    if (a == 32'h40)  return 32'h1234_5678;
    if (a == 32'h200) return 32'hCAFE_0001;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportMiss(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got event want none (cycle %0d)", name, cyc);
  endtask

  // Memory model: returns valid data only in the cycle MEM_LAT after the enable, garbage otherwise.
  int dueCyc = -1;
  logic [31:0] dueData = '0;
  always @(negedge clk) begin
    if (ramEn) begin
      dueCyc  = cyc + LAT;
      dueData = romVal(ramAddr);
    end
    ramRdata = (cyc == dueCyc) ? dueData : {16'hBAD0, cyc[15:0]};
  end

  // Monitor pops the scoreboard on each port event and re-issues queued requests after ready.
  always @(negedge clk) begin
    ramEv_t re;
    rdyEv_t de;
    #2;
    if (monOn) begin
      checkOutput("if_stall", {31'd0, ifStall}, {31'd0, ifReq & ~ifReady});
      checkOutput("mem_stall", {31'd0, memStall}, {31'd0, memReq & ~memReady});
      if (ramEn) begin
        if (ramQ.size() == 0) reportMiss("ram_en unexpected");
        else begin
          re = ramQ.pop_front();
          checkOutput("ram_en cycle", 32'(cyc), 32'(re.cyc));
          checkOutput("ram_we", {31'd0, ramWe}, {31'd0, re.we});
          checkOutput("ram_addr", ramAddr, re.addr);
          checkOutput("ram_wdata", ramWdata, re.wdata);
        end
      end
      if (ifReady) begin
        if (ifQ.size() == 0) reportMiss("if_ready unexpected");
        else begin
          de = ifQ.pop_front();
          checkOutput("if_ready cycle", 32'(cyc), 32'(de.cyc));
          checkOutput("if_rdata", ifRdata, de.data);
          checkOutput("mem_rdata stable", memRdata, expMemRdata);
          expIfRdata = de.data;
        end
        ifIdx++;
        if (ifIdx < ifN) ifAddr = 32'h40 + 32'(4 * ifIdx);
        else ifReq = 1'b0;
      end
      if (memReady) begin
        if (memQ.size() == 0) reportMiss("mem_ready unexpected");
        else begin
          de = memQ.pop_front();
          checkOutput("mem_ready cycle", 32'(cyc), 32'(de.cyc));
          if (de.isWrite) checkOutput("mem_rdata hold", memRdata, expMemRdata);
          else begin
            checkOutput("mem_rdata", memRdata, de.data);
            expMemRdata = de.data;
          end
          checkOutput("if_rdata stable", ifRdata, expIfRdata);
        end
        memIdx++;
        if (memIdx < memN) begin
          memAddr  = memBaseCur + 32'(4 * memIdx);
          memWdata = 32'hDEAD_BEEF + 32'(memIdx);
        end else memReq = 1'b0;
      end
    end
  end

  task automatic waitDrained(input string name);
    int w;
    for (w = 0; w < 400; w++) begin
      if (ramQ.size() == 0 && ifQ.size() == 0 && memQ.size() == 0 && !ifReq && !memReq) break;
      @(negedge clk);
    end
    checkOutput(name, 32'(ramQ.size() + ifQ.size() + memQ.size()), 32'd0);
    ramQ.delete();
    ifQ.delete();
    memQ.delete();
    ifReq  = 1'b0;
    memReq = 1'b0;
  endtask

  // Each grant k starts an access 3+MEM_LAT cycles after the previous one.
  task automatic applyStimulus(input vec_t v);
    int t0, tk, mi, ii;
    logic [31:0] a;
    @(negedge clk);
    #1;
    t0 = cyc;
    mi = 0;
    ii = 0;
    for (int k = 0; k < v.nGrants; k++) begin
      tk = t0 + k * (3 + LAT);
      if (v.memMask[k]) begin
        a = v.memBase + 32'(4 * mi);
        ramQ.push_back('{tk + 1, v.memWe, a, 32'hDEAD_BEEF + 32'(mi)});
        memQ.push_back('{tk + 2 + LAT, v.memWe, romVal(a)});
        mi++;
      end else begin
        a = 32'h40 + 32'(4 * ii);
        ramQ.push_back('{tk + 1, 1'b0, a, 32'h0});
        ifQ.push_back('{tk + 2 + LAT, 1'b0, romVal(a)});
        ii++;
      end
    end
    ifN        = v.ifN;
    memN       = v.memN;
    ifIdx      = 0;
    memIdx     = 0;
    memBaseCur = v.memBase;
    ifAddr     = 32'h40;
    ifReq      = (v.ifN > 0);
    memWe      = v.memWe;
    memAddr    = v.memBase;
    memWdata   = 32'hDEAD_BEEF;
    memReq     = (v.memN > 0);
    waitDrained("row drained");
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ram_en"}, {31'd0, ramEn}, 32'd0);
    checkOutput({tag, " ram_we"}, {31'd0, ramWe}, 32'd0);
    checkOutput({tag, " ram_addr"}, ramAddr, 32'd0);
    checkOutput({tag, " ram_wdata"}, ramWdata, 32'd0);
    checkOutput({tag, " if_ready"}, {31'd0, ifReady}, 32'd0);
    checkOutput({tag, " mem_ready"}, {31'd0, memReady}, 32'd0);
    checkOutput({tag, " if_rdata"}, ifRdata, 32'd0);
    checkOutput({tag, " mem_rdata"}, memRdata, 32'd0);
    checkOutput({tag, " if_stall"}, {31'd0, ifStall}, {31'd0, ifReq});
    checkOutput({tag, " mem_stall"}, {31'd0, memStall}, {31'd0, memReq});
  endtask

  vec_t vecs[5];
  int t0, t1;

  initial begin
    vecs[0] = '{1, 0, 1'b0, 32'h100, 16'h0000, 1};
    vecs[1] = '{1, 1, 1'b1, 32'h100, 16'h0001, 2};
    vecs[2] = '{0, 1, 1'b0, 32'h200, 16'h0001, 1};
    vecs[3] = '{2, 6, 1'b0, 32'h200, 16'h006F, 8};
    vecs[4] = '{2, 0, 1'b0, 32'h100, 16'h0000, 2};

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      ifReq    = 1'($urandom_range(0, 1));
      memReq   = 1'($urandom_range(0, 1));
      memWe    = 1'($urandom_range(0, 1));
      ifAddr   = $urandom;
      memAddr  = $urandom;
      memWdata = $urandom;
      #1;
      checkAllZero("reset");
    end
    ifReq  = 1'b0;
    memReq = 1'b0;
    @(negedge clk);
    #1;
    rstN  = 1'b1;
    monOn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Reset while an access is waiting on memory: it must vanish and be re-served afresh.
    @(negedge clk);
    #1;
    t0 = cyc;
    ramQ.push_back('{t0 + 1, 1'b0, 32'h300, 32'h1111_2222});
    memN       = 1;
    memIdx     = 0;
    memBaseCur = 32'h300;
    memWe      = 1'b0;
    memAddr    = 32'h300;
    memWdata   = 32'h1111_2222;
    memReq     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    rstN        = 1'b0;
    expIfRdata  = '0;
    expMemRdata = '0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    #1;
    rstN = 1'b1;
    t1   = cyc;
    ramQ.push_back('{t1 + 1, 1'b0, 32'h300, 32'h1111_2222});
    memQ.push_back('{t1 + 2 + LAT, 1'b0, romVal(32'h300)});
    waitDrained("reset recovery drained");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage data-memory access).
It sequences each access through a small FSM, drives the memory port from registers and returns read data to the owning requester with a one-cycle ready pulse.
It raises per-requester stall signals to freeze the pipeline.
MEM has priority over IF, with a starvation guard for IF.

Parameters:
ADDR_W, 32, address width of both requesters and memory port
DATA_W, 32, data width
MEM_LAT, 2, cycles from ram_en cycle to valid ram_rdata; legal range 1..15
STARVE_MAX, 4, consecutive contested MEM wins after which IF is forced to win; legal range 1..15

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  IF read request; held with if_addr stable until if_ready
if_addr  in  ADDR_W  IF read address
if_ready  out  1  one-cycle pulse: if_rdata valid, request consumed
if_rdata  out  DATA_W  registered IF read data
if_stall  out  1  if_req & ~if_ready (combinational)
mem_req  in  1  MEM-stage request; held with fields stable until mem_ready
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  data address (ALU result)
mem_wdata  in  DATA_W  store data
mem_ready  out  1  one-cycle pulse: access complete
mem_rdata  out  DATA_W  registered load data
mem_stall  out  1  mem_req & ~mem_ready (combinational)
ram_en  out  1  memory enable, one-cycle pulse per access
ram_we  out  1  memory write enable, valid with ram_en
ram_addr  out  ADDR_W  memory address, passed unmodified
ram_wdata  out  DATA_W  memory write data
ram_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after ram_en

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0: ram_en, ram_we, ram_addr, ram_wdata, if_ready, mem_ready, if_rdata, mem_rdata.
  - owner=IF; starve_cnt=0; lat_cnt=0.
  - An in-flight access is abandoned: no ready pulse, no data returned.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no request: stay; ram_en=0.
- IDLE, any request (cycle T):
  - Pick winner; latch owner, we, addr, wdata.
  - Next cycle (T+1): ram_en=1, ram_we=latched we (0 for IF), ram_addr, ram_wdata (0 for IF); lat_cnt=MEM_LAT; state→WAIT.
- Priority:
  - MEM only → MEM. IF only → IF.
  - Both asserted → MEM, unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt:
  - +1 on each MEM grant while if_req=1 (saturates at STARVE_MAX).
  - Cleared on IF grant, or on a MEM grant with if_req=0.
- WAIT:
  - ram_en, ram_we return to 0 after the single enable cycle; ram_addr, ram_wdata hold.
  - lat_cnt decrements each cycle.
  - In cycle E+MEM_LAT (E = ram_en cycle), ram_rdata is captured into the owner's rdata register; state→RESP.
- RESP (one cycle, E+MEM_LAT+1):
  - Owner's ready=1; other ready=0.
  - Write: mem_rdata keeps its previous value; only mem_ready pulses.
  - Next state IDLE unconditionally. Requests are not sampled in RESP, so a request still held during its ready cycle is never re-served.
- Latency: request seen in IDLE at T → ram_en at T+1 → ready at T+2+MEM_LAT.
- The non-owner's request is ignored until IDLE; its stall stays high.
- Requester fields changing mid-access are ignored (latched at grant).
- if_rdata and mem_rdata are otherwise stable between captures.

Test Plan:
1. Reset: rst_n=0 with random inputs → all outputs 0, if_stall=if_req, mem_stall=mem_req; release → IDLE.
2. IF read, MEM_LAT=2: if_req=1, if_addr=0x40 at cycle 0; ram_rdata=0x12345678 at cycle 3 → ram_en=1, ram_addr=0x40 in cycle 1 only; if_ready pulse in cycle 4 with if_rdata=0x12345678; if_stall=1 in cycles 0–3.
3. Simultaneous requests, cycle 0: if_req=1 (0x40) and mem_req=1, mem_we=1 (addr 0x100, wdata 0xDEADBEEF):
   - MEM first: ram_en, ram_we=1 in cycle 1; mem_ready in cycle 4; mem_rdata unchanged.
   - IF next: ram_en in cycle 6; if_ready in cycle 9.
4. Starvation, STARVE_MAX=4: if_req held high, MEM re-requests every IDLE → grant order M,M,M,M,I,M…; starve_cnt returns to 0 after the IF grant.
5. MEM load: mem_req=1, mem_we=0, addr 0x200, ram_rdata=0xCAFE0001 → mem_ready at T+2+MEM_LAT with mem_rdata=0xCAFE0001; if_rdata unchanged.
6. Reset mid-access: rst_n=0 during WAIT → no ready pulse, outputs 0 immediately. After release, the held mem_req is re-granted from IDLE with full latency.
